// File: rtl/h80_uart_tx_if.sv
// rtl/h80_uart_tx_if.sv - push/status/serial bundle between the io decoder and h80_uart_tx
//
// Purpose: groups the byte-push handshake, status readback and serial line.
//   master: io port decoder side (drives wr_en/wr_data/clr_ovf)
//   slave : h80_uart_tx side (drives wr_ready/fifo_count/busy/overflow/tx)
// Signals:
//   wr_en      push request
//   wr_data    byte to push
//   wr_ready   1 = FIFO not full
//   fifo_count bytes queued, excluding the byte being shifted
//   busy       FSM active or bytes queued
//   overflow   sticky push-while-full flag
//   clr_ovf    clears overflow (a same-cycle set wins)
//   tx         serial line, idle high
// FIFO_DEPTH must match the FIFO_DEPTH of the attached h80_uart_tx.

interface h80_uart_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  logic                        wr_en;
  logic [7:0]                  wr_data;
  logic                        wr_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        busy;
  logic                        overflow;
  logic                        clr_ovf;
  logic                        tx;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  wr_ready, fifo_count, busy, overflow, tx
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output wr_ready, fifo_count, busy, overflow, tx
  );
endinterface

// File: rtl/h80_uart_tx.sv
// rtl/h80_uart_tx.sv - buffered 8N1/8E1 UART transmitter on the sysclk domain
//
// Purpose: FIFO-buffered serial transmitter fed one byte per OUT instruction by
//   the io port decoder; status returns to the decoder for IN reads.
// Parameters:
//   BAUD_DIV   sysclk cycles per bit, 2..65535
//   FIFO_DEPTH byte entries, power of two, 2..256
// Ports:
//   i_clk      sysclk, all state on posedge
//   i_reset    asynchronous active-high reset, clears all state
//   io_uart    h80_uart_tx_if.slave (push handshake, status, tx line)
// Configuration macro:
//   H80_UART_PARITY_EN  adds an even parity bit between data and stop (8E1)

module h80_uart_tx #(
  parameter int BAUD_DIV   = 234,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  h80_uart_tx_if.slave io_uart
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam int             CW         = AW + 1;
  localparam logic [CW-1:0]  COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0]    TIMER_MAX  = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef H80_UART_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  // FIFO storage and control
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  // transmitter state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_tx;
`ifdef H80_UART_PARITY_EN
  logic          r_par;
`endif

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_shift;
  logic          w_tx_nxt;
  logic          w_tick;
  logic          w_last_bit;
  logic          w_have_data;
  logic [7:0]    w_rd_data;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never opens room for a push into a full FIFO.
  assign w_full      = (r_count == COUNT_FULL);
  assign w_push      = io_uart.wr_en && !w_full;
  assign w_have_data = (r_count != '0);
  assign w_rd_data   = r_mem[r_rd_ptr];
  assign w_tick      = (r_timer == 16'd0);
  assign w_last_bit  = (r_bit_idx == 3'd7);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_uart.wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A rejected push outranks a clear in the same cycle.
      if (io_uart.wr_en && w_full) begin
        r_ovf <= 1'b1;
      end else if (io_uart.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_have_data) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tick && w_last_bit) begin
`ifdef H80_UART_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef H80_UART_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit so frames run back to back.
        if (w_tick) w_state_nxt = w_have_data ? S_START : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered: this block picks the level for the next bit period,
  // which the datapath register applies on the same edge as the state change.
  always_comb begin
    w_pop    = 1'b0;
    w_shift  = 1'b0;
    w_tx_nxt = r_tx;
    case (r_state)
      S_IDLE: begin
        if (w_have_data) begin
          w_pop    = 1'b1;
          w_tx_nxt = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) w_tx_nxt = r_shreg[0];
      end
      S_DATA: begin
        if (w_tick) begin
          if (w_last_bit) begin
`ifdef H80_UART_PARITY_EN
            w_tx_nxt = r_par;
`else
            w_tx_nxt = 1'b1;
`endif
          end else begin
            // shreg[1] becomes shreg[0] on this edge
            w_shift  = 1'b1;
            w_tx_nxt = r_shreg[1];
          end
        end
      end
`ifdef H80_UART_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_tx_nxt = 1'b1;
      end
`endif
      S_STOP: begin
        if (w_tick && w_have_data) begin
          w_pop    = 1'b1;
          w_tx_nxt = 1'b0;
        end else if (w_tick) begin
          w_tx_nxt = 1'b1;
        end
      end
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // The timer sits at TIMER_MAX while idle and reloads on every tick, so each
  // bit period starts with a full count without a separate load strobe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx      <= 1'b1;
      r_timer   <= TIMER_MAX;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'd0;
`ifdef H80_UART_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_tx    <= w_tx_nxt;
      r_timer <= (w_tick || (r_state == S_IDLE)) ? TIMER_MAX : (r_timer - 16'd1);
      if (w_pop) begin
        r_shreg   <= w_rd_data;
        r_bit_idx <= 3'd0;
`ifdef H80_UART_PARITY_EN
        r_par     <= ^w_rd_data;
`endif
      end else if (w_shift) begin
        r_shreg   <= {1'b0, r_shreg[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign io_uart.wr_ready   = !w_full;
  assign io_uart.fifo_count = r_count;
  assign io_uart.busy       = (r_state != S_IDLE) || w_have_data;
  assign io_uart.overflow   = r_ovf;
  assign io_uart.tx         = r_tx;

endmodule
